// File: rtl/spi_write_queue.sv
// spi_write_queue: show-ahead FIFO that decouples SPI-received address/data
// writes from an intermittently busy memory/framebuffer port. Dropped writes
// raise a sticky overflow flag.
module spi_write_queue #(
    parameter int unsigned ADDRESS_BUS_WIDTH = 16,
    parameter int unsigned DATA_BUS_WIDTH    = 16,
    parameter int unsigned DEPTH             = 16,
    localparam int unsigned PTR_W            = $clog2(DEPTH),
    localparam int unsigned LEVEL_W          = PTR_W + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_strobe,
    input  logic [ADDRESS_BUS_WIDTH-1:0] address,
    input  logic [DATA_BUS_WIDTH-1:0]    data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [ADDRESS_BUS_WIDTH-1:0] out_address,
    output logic [DATA_BUS_WIDTH-1:0]    out_data,
    output logic [LEVEL_W-1:0]           level,
    output logic                         full,
    output logic                         overflow,
    input  logic                         overflow_clear
);

    localparam int unsigned ENTRY_W = ADDRESS_BUS_WIDTH + DATA_BUS_WIDTH;

    logic [ENTRY_W-1:0]           r_mem [DEPTH];
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [LEVEL_W-1:0]           r_level;
    logic                         r_out_valid;
    logic                         r_full;
    logic                         r_overflow;
    logic [ADDRESS_BUS_WIDTH-1:0] r_out_address;
    logic [DATA_BUS_WIDTH-1:0]    r_out_data;

    logic                         w_pop;
    logic                         w_push;
    logic                         w_drop;
    logic [LEVEL_W-1:0]           w_level_next;
    logic [PTR_W-1:0]             w_rd_ptr_next;
    logic                         w_bypass;
    logic [ENTRY_W-1:0]           w_head_next;

    // A full queue still accepts a push when the head leaves on the same edge.
    assign w_pop  = r_out_valid & out_ready;
    assign w_push = write_strobe & (~r_full | w_pop);
    assign w_drop = write_strobe & r_full & ~w_pop;

    // Next level, next read pointer and the entry that will sit at the head.
    always_comb begin
        w_level_next  = r_level;
        w_rd_ptr_next = r_rd_ptr;
        w_bypass      = 1'b0;
        w_head_next   = '0;
        case ({w_push, w_pop})
            2'b10:   w_level_next = r_level + LEVEL_W'(1);
            2'b01:   w_level_next = r_level - LEVEL_W'(1);
            default: w_level_next = r_level;
        endcase
        if (w_pop) begin
            w_rd_ptr_next = r_rd_ptr + PTR_W'(1);
        end
        // The incoming entry lands on the next head slot only when the queue
        // is (or becomes) otherwise empty; forward it past the RAM write.
        w_bypass    = w_push && (r_wr_ptr == w_rd_ptr_next);
        w_head_next = w_bypass ? {address, data} : r_mem[w_rd_ptr_next];
    end

    // Queue storage; not reset.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr_ptr] <= {address, data};
        end
    end

    // Pointers, level, status flags and registered head entry.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_level       <= '0;
            r_out_valid   <= 1'b0;
            r_full        <= 1'b0;
            r_overflow    <= 1'b0;
            r_out_address <= '0;
            r_out_data    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            r_rd_ptr      <= w_rd_ptr_next;
            r_level       <= w_level_next;
            r_out_valid   <= (w_level_next != '0);
            r_full        <= (w_level_next == LEVEL_W'(DEPTH));
            r_out_address <= w_head_next[ENTRY_W-1:DATA_BUS_WIDTH];
            r_out_data    <= w_head_next[DATA_BUS_WIDTH-1:0];
            // A drop wins over a simultaneous clear.
            if (w_drop) begin
                r_overflow <= 1'b1;
            end else if (overflow_clear) begin
                r_overflow <= 1'b0;
            end
        end
    end

    assign out_valid   = r_out_valid;
    assign out_address = r_out_address;
    assign out_data    = r_out_data;
    assign level       = r_level;
    assign full        = r_full;
    assign overflow    = r_overflow;

endmodule

// File: tb/tb_spi_write_queue.sv
// Self-checking bench for spi_write_queue: a queue scoreboard tracks every
// accepted write and compares the head/flags each cycle, plus directed checks.
module tb_spi_write_queue;

    localparam int unsigned AW    = 16;
    localparam int unsigned DW    = 16;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned LW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          write_strobe;
    logic [AW-1:0] address;
    logic [DW-1:0] data;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_address;
    logic [DW-1:0] out_data;
    logic [LW-1:0] level;
    logic          full;
    logic          overflow;
    logic          overflow_clear;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] sb_q [$];
    logic        m_ovf   = 1'b0;
    logic        m_known = 1'b0;

    spi_write_queue #(
        .ADDRESS_BUS_WIDTH(AW),
        .DATA_BUS_WIDTH   (DW),
        .DEPTH            (DEPTH)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .write_strobe  (write_strobe),
        .address       (address),
        .data          (data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_address   (out_address),
        .out_data      (out_data),
        .level         (level),
        .full          (full),
        .overflow      (overflow),
        .overflow_clear(overflow_clear)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: check outputs against the model, then advance the model
    // with the inputs that the coming posedge will sample.
    always @(negedge clk) begin
        logic pop;
        logic push;
        if (m_known) begin
            check("valid", 32'(out_valid), 32'(sb_q.size() != 0));
            check("level", 32'(level), 32'(sb_q.size()));
            check("full", 32'(full), 32'(sb_q.size() == DEPTH));
            check("ovf", 32'(overflow), 32'(m_ovf));
            if (sb_q.size() != 0) begin
                check("head", {out_address, out_data}, sb_q[0]);
            end
        end
        if (reset) begin
            sb_q.delete();
            m_ovf   = 1'b0;
            m_known = 1'b1;
        end else if (m_known) begin
            pop  = (sb_q.size() != 0) && out_ready;
            push = write_strobe && ((sb_q.size() < DEPTH) || pop);
            if (pop) void'(sb_q.pop_front());
            if (push) sb_q.push_back({address, data});
            if (write_strobe && !push) m_ovf = 1'b1;
            else if (overflow_clear) m_ovf = 1'b0;
        end
    end

    task automatic strobe(input logic [15:0] a, input logic [15:0] d);
        write_strobe = 1'b1;
        address      = a;
        data         = d;
        tick();
        write_strobe = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int n;
        n = 0;
        out_ready = 1'b1;
        while (out_valid && n < max_cycles) begin
            tick();
            n++;
        end
        out_ready = 1'b0;
        check("drain_done", 32'(out_valid), 32'(0));
    endtask

    initial begin
        reset          = 1'b1;
        write_strobe   = 1'b0;
        address        = '0;
        data           = '0;
        out_ready      = 1'b0;
        overflow_clear = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check("rst_level", 32'(level), 32'(0));
        check("rst_valid", 32'(out_valid), 32'(0));
        check("rst_full", 32'(full), 32'(0));
        check("rst_ovf", 32'(overflow), 32'(0));
        check("rst_head", {out_address, out_data}, 32'(0));

        // Single write
        strobe(16'h0010, 16'hBEEF);
        check("sw_valid", 32'(out_valid), 32'(1));
        check("sw_addr", 32'(out_address), 32'h0010);
        check("sw_data", 32'(out_data), 32'hBEEF);
        check("sw_level", 32'(level), 32'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sw_pop_level", 32'(level), 32'(0));
        check("sw_pop_valid", 32'(out_valid), 32'(0));

        // Burst with stall
        for (int i = 0; i < 5; i++) strobe(16'h0100 + 16'(i), 16'hA000 + 16'(i));
        for (int i = 0; i < 3; i++) begin
            check("stall_head", 32'(out_address), 32'h0100);
            tick();
        end
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("burst_addr", 32'(out_address), 32'h0100 + 32'(i));
            check("burst_data", 32'(out_data), 32'hA000 + 32'(i));
            check("burst_level", 32'(level), 32'(5 - i));
            tick();
        end
        out_ready = 1'b0;
        check("burst_empty", 32'(level), 32'(0));

        // Fill and overflow
        for (int i = 0; i < 16; i++) strobe(16'h0300 + 16'(i), 16'hC000 + 16'(i));
        check("fill_full", 32'(full), 32'(1));
        check("fill_level", 32'(level), 32'(16));
        check("fill_ovf0", 32'(overflow), 32'(0));
        strobe(16'h03FF, 16'hCFFF);
        check("drop_ovf", 32'(overflow), 32'(1));
        check("drop_level", 32'(level), 32'(16));
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("ovf_drain_addr", 32'(out_address), 32'h0300 + 32'(i));
            check("ovf_drain_data", 32'(out_data), 32'hC000 + 32'(i));
            tick();
        end
        out_ready = 1'b0;
        check("ovf_drain_empty", 32'(out_valid), 32'(0));
        check("ovf_sticky", 32'(overflow), 32'(1));
        overflow_clear = 1'b1;
        tick();
        overflow_clear = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'(0));

        // Full with simultaneous push and pop
        for (int i = 0; i < 16; i++) strobe(16'h0400 + 16'(i), 16'hD000 + 16'(i));
        out_ready = 1'b1;
        strobe(16'h0200, 16'h5555);
        out_ready = 1'b0;
        check("pp_level", 32'(level), 32'(16));
        check("pp_ovf", 32'(overflow), 32'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            check("pp_drain_addr", 32'(out_address), (i < 15) ? 32'h0401 + 32'(i) : 32'h0200);
            tick();
        end
        out_ready = 1'b0;
        check("pp_empty", 32'(out_valid), 32'(0));

        // Wrap-around: push with ready high, then an idle cycle with ready low
        for (int i = 0; i < 40; i++) begin
            out_ready = 1'b1;
            strobe(16'h0500 + 16'(i), 16'(i * 7));
            out_ready = 1'b0;
            tick();
            check("wrap_level_le3", 32'(level <= 3), 32'(1));
        end
        drain(8);

        // Reset mid-operation with a strobe during reset
        for (int i = 0; i < 7; i++) strobe(16'h0600 + 16'(i), 16'hE000 + 16'(i));
        reset = 1'b1;
        out_ready = 1'b1;
        strobe(16'hDEAD, 16'hBEEF);
        reset = 1'b0;
        out_ready = 1'b0;
        check("mrst_level", 32'(level), 32'(0));
        check("mrst_valid", 32'(out_valid), 32'(0));
        check("mrst_ovf", 32'(overflow), 32'(0));
        strobe(16'h0033, 16'h1234);
        check("mrst_addr", 32'(out_address), 32'h0033);
        check("mrst_data", 32'(out_data), 32'h1234);
        check("mrst_only", 32'(level), 32'(1));
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("mrst_empty", 32'(out_valid), 32'(0));

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
